// File: rtl/test_counter_pkg.sv
// Shared definitions for the test counter generator/checker pair.
package test_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 7;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        TRACK  = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/test_counter_checker.sv
// Receive-side checker for the incrementing test pattern: acquires lock, then
// counts sequence errors and captures the first one.
module test_counter_checker
    import test_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned LOCK_LEN = 4,
    parameter int unsigned LOSS_LEN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sample_count,
    output logic             first_err_valid,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_got
);

    localparam int unsigned GW = $clog2(LOCK_LEN + 1);
    localparam int unsigned BW = $clog2(LOSS_LEN + 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] prev, prev_n;
    logic [GW-1:0]    good_run, good_n;
    logic [BW-1:0]    bad_run, bad_n;
    logic             have_prev, have_n;
    logic [WIDTH-1:0] exp_val;
    logic             hit;
    logic             miss;
    logic             err_inc;
    logic             smp_inc;

    assign exp_val = prev + 1'b1;
    assign hit     = (in_data == exp_val);

    always_comb begin
        state_n = state;
        prev_n  = prev;
        good_n  = good_run;
        bad_n   = bad_run;
        have_n  = have_prev;
        miss    = 1'b0;
        if (in_valid) begin
            if (state == SEARCH) begin
                prev_n = in_data;
                have_n = 1'b1;
                if (have_prev) begin
                    if (hit) begin
                        good_n = good_run + 1'b1;
                        if (good_run == GW'(LOCK_LEN - 1)) begin
                            state_n = TRACK;
                            bad_n   = '0;
                        end
                    end else begin
                        good_n = '0;
                    end
                end
            end else begin
                if (hit) begin
                    prev_n = in_data;
                    bad_n  = '0;
                end else begin
                    // Flywheel on the expected value so a single bad word costs one error.
                    miss   = 1'b1;
                    prev_n = exp_val;
                    bad_n  = bad_run + 1'b1;
                    if (bad_run == BW'(LOSS_LEN - 1)) begin
                        state_n = SEARCH;
                        prev_n  = in_data;
                        good_n  = '0;
                        bad_n   = '0;
                    end
                end
            end
        end
    end

    // Clear takes priority over the coincident sample for statistics only.
    assign err_inc = miss & ~clear;
    assign smp_inc = in_valid & ~clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= SEARCH;
            prev            <= '0;
            good_run        <= '0;
            bad_run         <= '0;
            have_prev       <= 1'b0;
            err_pulse       <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_exp   <= '0;
            first_err_got   <= '0;
        end else begin
            state     <= state_n;
            prev      <= prev_n;
            good_run  <= good_n;
            bad_run   <= bad_n;
            have_prev <= have_n;
            err_pulse <= err_inc;
            if (clear) begin
                first_err_valid <= 1'b0;
                first_err_exp   <= '0;
                first_err_got   <= '0;
            end else if (err_inc && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_exp   <= exp_val;
                first_err_got   <= in_data;
            end
        end
    end

    assign locked = (state == TRACK);

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .clr   (clear),
        .q     (err_count)
    );

    sat_counter #(.W(CNT_W)) u_smp_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (smp_inc),
        .clr   (clear),
        .q     (sample_count)
    );

endmodule

// File: tb/tb_test_counter_checker.sv
// Directed bench for test_counter_checker: vector table plus multi-cycle corner sequences.
module tb_test_counter_checker;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [6:0]  in_data;
    logic        clear;

    logic        locked, err_pulse, first_err_valid;
    logic [15:0] err_count, sample_count;
    logic [6:0]  first_err_exp, first_err_got;

    logic        locked4, err_pulse4, first_err_valid4;
    logic [3:0]  err_count4, sample_count4;
    logic [6:0]  first_err_exp4, first_err_got4;

    int checks = 0;
    int errors = 0;

    test_counter_checker dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .clear           (clear),
        .locked          (locked),
        .err_pulse       (err_pulse),
        .err_count       (err_count),
        .sample_count    (sample_count),
        .first_err_valid (first_err_valid),
        .first_err_exp   (first_err_exp),
        .first_err_got   (first_err_got)
    );

    test_counter_checker #(.CNT_W(4)) dut4 (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .clear           (clear),
        .locked          (locked4),
        .err_pulse       (err_pulse4),
        .err_count       (err_count4),
        .sample_count    (sample_count4),
        .first_err_valid (first_err_valid4),
        .first_err_exp   (first_err_exp4),
        .first_err_got   (first_err_got4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         v;
        logic [6:0] d;
        bit         c;
        bit         lk;
        bit         pl;
        int         err;
        int         smp;
        bit         fv;
        logic [6:0] fe;
        logic [6:0] fg;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic add(input bit rst, input bit v, input logic [6:0] d, input bit c,
                       input bit lk, input bit pl, input int err, input int smp,
                       input bit fv, input logic [6:0] fe, input logic [6:0] fg);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.c = c; r.lk = lk; r.pl = pl;
        r.err = err; r.smp = smp; r.fv = fv; r.fe = fe; r.fg = fg;
        tbl.push_back(r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        in_data  = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input bit v, input logic [6:0] d, input bit c);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        clear    = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         cnt;
        logic [6:0] d;
        logic [6:0] p;
        bit         v;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        clear    = 1'b0;
        #12;
        chk("reset_locked", {31'd0, locked}, 32'd0);
        chk("reset_err_pulse", {31'd0, err_pulse}, 32'd0);
        chk("reset_err_count", {16'd0, err_count}, 32'd0);
        chk("reset_sample_count", {16'd0, sample_count}, 32'd0);
        chk("reset_first_err_valid", {31'd0, first_err_valid}, 32'd0);
        chk("reset_first_err_exp", {25'd0, first_err_exp}, 32'd0);

        // rst v  data  clr lk pl err smp fv  fe     fg
        // lock from reset, including the 7F->00 wrap
        add(1, 1, 7'h7F, 0, 0, 0, 0, 1, 0, 7'h00, 7'h00);
        add(0, 1, 7'h00, 0, 0, 0, 0, 2, 0, 7'h00, 7'h00);
        add(0, 1, 7'h01, 0, 0, 0, 0, 3, 0, 7'h00, 7'h00);
        add(0, 1, 7'h02, 0, 0, 0, 0, 4, 0, 7'h00, 7'h00);
        add(0, 1, 7'h03, 0, 1, 0, 0, 5, 0, 7'h00, 7'h00);
        // wrap while locked
        add(1, 1, 7'h78, 0, 0, 0, 0, 1, 0, 7'h00, 7'h00);
        add(0, 1, 7'h79, 0, 0, 0, 0, 2, 0, 7'h00, 7'h00);
        add(0, 1, 7'h7A, 0, 0, 0, 0, 3, 0, 7'h00, 7'h00);
        add(0, 1, 7'h7B, 0, 0, 0, 0, 4, 0, 7'h00, 7'h00);
        add(0, 1, 7'h7C, 0, 1, 0, 0, 5, 0, 7'h00, 7'h00);
        add(0, 1, 7'h7D, 0, 1, 0, 0, 6, 0, 7'h00, 7'h00);
        add(0, 1, 7'h7E, 0, 1, 0, 0, 7, 0, 7'h00, 7'h00);
        add(0, 1, 7'h7F, 0, 1, 0, 0, 8, 0, 7'h00, 7'h00);
        add(0, 1, 7'h00, 0, 1, 0, 0, 9, 0, 7'h00, 7'h00);
        add(0, 1, 7'h01, 0, 1, 0, 0, 10, 0, 7'h00, 7'h00);
        // single corruption, with an idle cycle after it
        add(1, 1, 7'h0C, 0, 0, 0, 0, 1, 0, 7'h00, 7'h00);
        add(0, 1, 7'h0D, 0, 0, 0, 0, 2, 0, 7'h00, 7'h00);
        add(0, 1, 7'h0E, 0, 0, 0, 0, 3, 0, 7'h00, 7'h00);
        add(0, 1, 7'h0F, 0, 0, 0, 0, 4, 0, 7'h00, 7'h00);
        add(0, 1, 7'h10, 0, 1, 0, 0, 5, 0, 7'h00, 7'h00);
        add(0, 1, 7'h55, 0, 1, 1, 1, 6, 1, 7'h11, 7'h55);
        add(0, 0, 7'h33, 0, 1, 0, 1, 6, 1, 7'h11, 7'h55);
        add(0, 1, 7'h12, 0, 1, 0, 1, 7, 1, 7'h11, 7'h55);
        add(0, 1, 7'h13, 0, 1, 0, 1, 8, 1, 7'h11, 7'h55);
        // loss and re-lock, then clear coincident with a bad sample
        add(1, 1, 7'h1C, 0, 0, 0, 0, 1, 0, 7'h00, 7'h00);
        add(0, 1, 7'h1D, 0, 0, 0, 0, 2, 0, 7'h00, 7'h00);
        add(0, 1, 7'h1E, 0, 0, 0, 0, 3, 0, 7'h00, 7'h00);
        add(0, 1, 7'h1F, 0, 0, 0, 0, 4, 0, 7'h00, 7'h00);
        add(0, 1, 7'h20, 0, 1, 0, 0, 5, 0, 7'h00, 7'h00);
        add(0, 1, 7'h00, 0, 1, 1, 1, 6, 1, 7'h21, 7'h00);
        add(0, 1, 7'h00, 0, 1, 1, 2, 7, 1, 7'h21, 7'h00);
        add(0, 1, 7'h00, 0, 0, 1, 3, 8, 1, 7'h21, 7'h00);
        add(0, 1, 7'h40, 0, 0, 0, 3, 9, 1, 7'h21, 7'h00);
        add(0, 1, 7'h41, 0, 0, 0, 3, 10, 1, 7'h21, 7'h00);
        add(0, 1, 7'h42, 0, 0, 0, 3, 11, 1, 7'h21, 7'h00);
        add(0, 1, 7'h43, 0, 0, 0, 3, 12, 1, 7'h21, 7'h00);
        add(0, 1, 7'h44, 0, 1, 0, 3, 13, 1, 7'h21, 7'h00);
        add(0, 1, 7'h45, 0, 1, 0, 3, 14, 1, 7'h21, 7'h00);
        add(0, 1, 7'h70, 1, 1, 0, 0, 0, 0, 7'h00, 7'h00);
        add(0, 0, 7'h00, 0, 1, 0, 0, 0, 0, 7'h00, 7'h00);
        add(0, 1, 7'h47, 0, 1, 0, 0, 1, 0, 7'h00, 7'h00);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i].v, tbl[i].d, tbl[i].c);
            chk($sformatf("vec%0d_locked", i), {31'd0, locked}, {31'd0, tbl[i].lk});
            chk($sformatf("vec%0d_err_pulse", i), {31'd0, err_pulse}, {31'd0, tbl[i].pl});
            chk($sformatf("vec%0d_err_count", i), {16'd0, err_count}, tbl[i].err);
            chk($sformatf("vec%0d_sample_count", i), {16'd0, sample_count}, tbl[i].smp);
            chk($sformatf("vec%0d_first_err_valid", i), {31'd0, first_err_valid}, {31'd0, tbl[i].fv});
            chk($sformatf("vec%0d_first_err_exp", i), {25'd0, first_err_exp}, {25'd0, tbl[i].fe});
            chk($sformatf("vec%0d_first_err_got", i), {25'd0, first_err_got}, {25'd0, tbl[i].fg});
        end

        // clean stream with random valid gaps
        do_reset();
        d   = '0;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            v = (i < 5) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            in_valid = v;
            in_data  = v ? d : 7'h5A;
            if (v) begin
                d = d + 7'd1;
                cnt++;
            end
        end
        step(1'b0, 7'h00, 1'b0);
        chk("gaps_locked", {31'd0, locked}, 32'd1);
        chk("gaps_err_count", {16'd0, err_count}, 32'd0);
        chk("gaps_sample_count", {16'd0, sample_count}, cnt);

        // alternating bad/good words against a 4-bit counter
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 7'(i), 1'b0);
        p = 7'h04;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, (p + 7'd1) ^ 7'h40, 1'b0);
            p = p + 7'd1;
            step(1'b1, p + 7'd1, 1'b0);
            p = p + 7'd1;
        end
        step(1'b0, 7'h00, 1'b0);
        chk("sat_err_count4", {28'd0, err_count4}, 32'd15);
        chk("sat_sample_count4", {28'd0, sample_count4}, 32'd15);
        chk("sat_locked4", {31'd0, locked4}, 32'd1);
        chk("sat_err_pulse4", {31'd0, err_pulse4}, 32'd0);
        chk("sat_first_err_valid4", {31'd0, first_err_valid4}, 32'd1);
        chk("sat_first_err_exp4", {25'd0, first_err_exp4}, 32'h05);
        chk("sat_first_err_got4", {25'd0, first_err_got4}, 32'h45);
        chk("sat_err_count_wide", {16'd0, err_count}, 32'd20);

        // asynchronous reset between edges while a stream is active
        step(1'b1, p + 7'd1, 1'b0);
        step(1'b1, p + 7'd9, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_locked", {31'd0, locked}, 32'd0);
        chk("areset_err_pulse", {31'd0, err_pulse}, 32'd0);
        chk("areset_err_count", {16'd0, err_count}, 32'd0);
        chk("areset_sample_count", {16'd0, sample_count}, 32'd0);
        chk("areset_first_err_valid", {31'd0, first_err_valid}, 32'd0);
        chk("areset_first_err_got", {25'd0, first_err_got}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step(1'b1, 7'h7F, 1'b0);
        step(1'b1, 7'h00, 1'b0);
        step(1'b1, 7'h01, 1'b0);
        step(1'b1, 7'h02, 1'b0);
        chk("relock_early_locked", {31'd0, locked}, 32'd0);
        step(1'b1, 7'h03, 1'b0);
        chk("relock_locked", {31'd0, locked}, 32'd1);
        chk("relock_sample_count", {16'd0, sample_count}, 32'd5);
        chk("relock_err_count", {16'd0, err_count}, 32'd0);

        @(negedge clk);
        in_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/test_counter_checker.md
# test_counter_checker

Receive-side companion to the free-running test counter pattern generator. Consumes the WIDTH-bit incrementing test stream (mod 2^WIDTH, wrap allowed) on a valid qualifier, acquires sequence lock, then counts and captures sequence errors. Sits at the far end of any datapath under test (FIFO, serializer, compression stage), so that path can be verified in hardware against the generator.

## Interface
- WIDTH, 7: data width; the sequence is modulo 2^WIDTH.
- CNT_W, 16: width of the saturating error and sample counters.
- LOCK_LEN, 4: consecutive correct increments required to lock, ≥1.
- LOSS_LEN, 3: consecutive mismatches while locked that drop lock, ≥1.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is a sample this cycle.
- in_data  in  WIDTH  received pattern word.
- clear  in  1  synchronous clear of statistics; lock state is unaffected.
- locked  out  1  checker is tracking the sequence.
- err_pulse  out  1  one-cycle pulse per counted mismatch.
- err_count  out  CNT_W  saturating count of mismatches while locked.
- sample_count  out  CNT_W  saturating count of all accepted samples.
- first_err_valid  out  1  first_err_exp and first_err_got hold a capture.
- first_err_exp  out  WIDTH  expected value at the first error.
- first_err_got  out  WIDTH  received value at the first error.

## Operation
- A sample is accepted only on a cycle where in_valid=1. With in_valid=0, no state, counter, or output changes, except that err_pulse returns to 0.
- Internal registers: prev (WIDTH), good_run (0..LOCK_LEN), bad_run (0..LOSS_LEN), and state {SEARCH, TRACK}.
- Expected value is exp = prev + 1, truncated to WIDTH bits, so 2^WIDTH−1 followed by 0 is correct.
- SEARCH behaviour:
  - The first sample after reset or after loss of lock only loads prev; good_run=0.
  - Each later sample: if in_data==exp then good_run++, else good_run=0. prev<=in_data in both cases.
  - When good_run reaches LOCK_LEN: go to TRACK, bad_run=0.
  - No errors are counted in SEARCH.
- TRACK behaviour, on a match:
  - prev<=in_data; bad_run=0.
- TRACK behaviour, on a mismatch:
  - err_pulse=1, err_count++ (saturating).
  - If first_err_valid=0, capture exp and in_data and set first_err_valid.
  - prev<=exp (flywheel), so one corrupted word costs exactly one error.
  - bad_run++. When it reaches LOSS_LEN: go to SEARCH, prev<=in_data, good_run=0.
- sample_count increments on every accepted sample in both states.
- Both counters saturate at 2^CNT_W−1 and never wrap.
- clear=1:
  - err_count, sample_count, first_err_* go to 0 on the next edge.
  - If an accepted sample coincides with clear, clear wins for statistics (that sample is neither counted nor captured), but the sample still advances prev, the runs, and the state.
- Reset values: state=SEARCH, locked=0, err_pulse=0, both counters 0, first_err_valid=0, first_err_exp=0, first_err_got=0, prev=0, runs=0.

## Timing
- All outputs are registered.
- Latency for err_pulse, counter updates, and capture: 1 cycle after the accepted sample's edge.
- locked rises on the edge that accepts the LOCK_LEN-th consecutive increment. It falls on the edge that accepts the LOSS_LEN-th consecutive mismatch.
- Throughput: one sample per cycle; back-to-back valids are fully supported.
- Reset mid-stream clears everything asynchronously. Re-lock needs LOCK_LEN+1 samples after deassertion.

## Structure
- Package test_counter_pkg holds the state enum (SEARCH, TRACK) and the default WIDTH constant, shared with the generator.
- One sub-module, sat_counter (parameter W; inputs inc and clr; output q; saturating), instantiated twice: for err_count and sample_count.
- The state machine and compare logic live in the top module.

## Test plan
- Lock from reset (defaults): samples 7F,00,01,02,03 on consecutive cycles → locked=1 after 03; sample_count=5; err_count=0.
- Wrap: locked, feed 7D,7E,7F,00,01 → no err_pulse; locked stays 1.
- Single corruption: locked at 10, feed 55,12,13 → exactly one err_pulse; err_count=1; first_err_exp=11, first_err_got=55; locked stays 1.
- Loss and re-lock: locked at 20, feed 00,00,00 → locked=0 after the third; err_count=3. Then feed 40..44 → locked=1; err_count still 3.
- Gaps, saturation, and clear:
  - Random in_valid gaps on a clean stream → no errors; sample_count equals the number of valid cycles.
  - With CNT_W=4, alternate bad and good words 20 times → err_count=15.
  - clear coincident with a bad sample → all statistics 0; locked unchanged.
- Async reset mid-stream: assert rst_n=0 between edges → all outputs 0 immediately. Then 7F,00..03 re-locks as in the first scenario.
